// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the buffered UART transmitter.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   DATA_BITS  = 8;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with registered occupancy; full/empty derive from level.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstd,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push on a full FIFO is dropped even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  // Storage write port.
  // NOTE: the data array is deliberately not reset; only pointers and level
  // carry meaning after reset, and a reset on the array would block RAM mapping.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a back-to-back serializer.
module uart_tx_buffered
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                          clk,
  input  logic                          rstd,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          ovf_clr,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          uart_tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t  state, state_d;
  logic [CW-1:0] baud_cnt, baud_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    shift_reg, shift_d;
  logic          tx_d;
  logic          pop;
  logic          baud_wrap;
  logic [7:0]    head;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rstd    (rstd),
    .push    (wr_en),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign busy      = (state != IDLE);
  assign baud_wrap = (baud_cnt == CW'(CLKS_PER_BIT - 1));

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd)                overflow <= 1'b0;
    else if (wr_en && full)   overflow <= 1'b1;
    else if (ovf_clr)         overflow <= 1'b0;
  end

  // Next-state, counters and next line level for the serializer.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_idx;
    shift_d = shift_reg;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_cnt + CW'(1);
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_d  = '0;
          shift_d = shift_reg >> 1;
          if (bit_idx == 3'(DATA_BITS - 1)) state_d = STOP;
          else                              bit_d   = bit_idx + 3'd1;
        end else begin
          baud_d = baud_cnt + CW'(1);
        end
      end
      STOP: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (!empty) begin
            // Chain straight into the next frame with no idle gap.
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The line is registered, so its next value follows the next state.
    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift_d[0];
      STOP:    tx_d = STOP_BIT;
      default: tx_d = IDLE_LEVEL;
    endcase
  end

  // Serializer state register; reset forces the line idle-high at once.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      uart_tx   <= IDLE_LEVEL;
    end else begin
      state     <= state_d;
      baud_cnt  <= baud_d;
      bit_idx   <= bit_d;
      shift_reg <= shift_d;
      uart_tx   <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with CLKS_PER_BIT=4, FIFO_DEPTH=16.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       rstd;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       ovf_clr;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       busy;
  logic       uart_tx;

  int n_cmp = 0;
  int n_err = 0;
  int max_level;

  // Passive receiver state (samples mid-bit on the falling edge).
  logic [7:0] rx_q[$];
  logic [7:0] rx_sh;
  int         rx_cnt;
  bit         rx_active = 1'b0;
  int         rx_ferr = 0;

  uart_tx_buffered #(
    .FIFO_DEPTH   (16),
    .CLKS_PER_BIT (4)
  ) dut (
    .clk      (clk),
    .rstd     (rstd),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .ovf_clr  (ovf_clr),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .busy     (busy),
    .uart_tx  (uart_tx)
  );

  always #5 clk = ~clk;

  // Frame decoder: start seen at count 0, data bits at 6,10,..,34, stop at 38.
  always @(negedge clk) begin
    if (!rstd) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (uart_tx == 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 2) % 4 == 0))
        rx_sh[(rx_cnt - 6) / 4] = uart_tx;
      if (rx_cnt == 38) begin
        if (uart_tx !== 1'b1) rx_ferr++;
        rx_q.push_back(rx_sh);
        rx_active = 1'b0;
      end
    end
  end

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Checks a full 10-bit frame cycle by cycle; first_now means the first
  // sample is the current negedge.
  task automatic check_frame(input logic [7:0] d, input bit first_now, input string name);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (!(first_now && i == 0 && c == 0)) @(negedge clk);
        if (int'(level) > max_level) max_level = int'(level);
        n_cmp++;
        if (uart_tx !== fr[i]) begin
          n_err++;
          $display("FAIL %s bit%0d cyc%0d: uart_tx=%b expected %b", name, i, c, uart_tx, fr[i]);
        end
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int budget;
    budget = 2000;
    while ((busy || !empty) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_cmp++;
    if (budget == 0) begin
      n_err++;
      $display("FAIL %s: timeout waiting idle, busy=%b empty=%b expected 0/1", name, busy, empty);
    end
  endtask

  task automatic test_reset;
    rstd = 1'b0; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({uart_tx, full, empty, level, overflow, busy} !== {1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset: tx/full/empty/level/ovf/busy=%b/%b/%b/%0d/%b/%b expected 1/0/1/0/0/0",
               uart_tx, full, empty, level, overflow, busy);
    end
    rstd = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    rx_q.delete();
    write_byte(8'hA5);
    n_cmp++;
    if (uart_tx !== 1'b1) begin
      n_err++;
      $display("FAIL single_pre: uart_tx=%b expected 1", uart_tx);
    end
    check_frame(8'hA5, 1'b0, "single");
    @(negedge clk);
    n_cmp++;
    if ({busy, empty, uart_tx} !== 3'b011) begin
      n_err++;
      $display("FAIL single_post: busy/empty/tx=%b%b%b expected 011", busy, empty, uart_tx);
    end
  endtask

  task automatic test_back_to_back;
    rx_q.delete();
    max_level = 0;
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h00;
    @(negedge clk);
    wr_data = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    n_cmp++;
    if (level !== 5'd1) begin
      n_err++;
      $display("FAIL b2b_level: level=%0d expected 1", level);
    end
    check_frame(8'h00, 1'b1, "b2b_frame0");
    check_frame(8'hFF, 1'b0, "b2b_frame1");
    n_cmp++;
    if (max_level != 1) begin
      n_err++;
      $display("FAIL b2b_peak: max level=%0d expected 1", max_level);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_done: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_full_overflow;
    rx_q.delete();
    write_byte(8'h55);
    @(negedge clk);
    n_cmp++;
    if ({busy, empty} !== 2'b11) begin
      n_err++;
      $display("FAIL full_setup: busy/empty=%b%b expected 11", busy, empty);
    end
    for (int i = 1; i <= 17; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      @(negedge clk);
      if (i == 15 || i == 16 || i == 17) begin
        n_cmp++;
        if ({full, level, overflow} !== {(i >= 16), (i == 15) ? 5'd15 : 5'd16, (i == 17)}) begin
          n_err++;
          $display("FAIL full_w%0d: full/level/ovf=%b/%0d/%b expected %b/%0d/%b", i, full, level,
                   overflow, (i >= 16), (i == 15) ? 15 : 16, (i == 17));
        end
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_ovf_priority;
    wr_en = 1'b1; wr_data = 8'h12; ovf_clr = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; ovf_clr = 1'b0;
    n_cmp++;
    if ({overflow, level} !== {1'b1, 5'd16}) begin
      n_err++;
      $display("FAIL ovf_prio: ovf/level=%b/%0d expected 1/16", overflow, level);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clr: overflow=%b expected 0", overflow);
    end
  endtask

  task automatic test_drain;
    logic [7:0] exp;
    wait_idle("drain");
    n_cmp++;
    if (rx_q.size() != 17) begin
      n_err++;
      $display("FAIL drain_count: frames=%0d expected 17", rx_q.size());
    end
    for (int k = 0; k < 17 && k < rx_q.size(); k++) begin
      exp = (k == 0) ? 8'h55 : 8'(k);
      n_cmp++;
      if (rx_q[k] !== exp) begin
        n_err++;
        $display("FAIL drain_byte%0d: got %h expected %h", k, rx_q[k], exp);
      end
    end
  endtask

  task automatic test_push_pop;
    logic [7:0] exp_bytes [3];
    exp_bytes = '{8'h5A, 8'hC3, 8'h96};
    rx_q.delete();
    write_byte(8'h5A);
    repeat (4) @(negedge clk);
    wr_en = 1'b1; wr_data = 8'hC3;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (35) @(negedge clk);
    n_cmp++;
    if ({level, uart_tx, busy} !== {5'd1, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL pp_stop: level/tx/busy=%0d/%b/%b expected 1/1/1", level, uart_tx, busy);
    end
    wr_en = 1'b1; wr_data = 8'h96;
    @(negedge clk);
    wr_en = 1'b0;
    n_cmp++;
    if ({level, uart_tx, busy} !== {5'd1, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL pp_wrap: level/tx/busy=%0d/%b/%b expected 1/0/1", level, uart_tx, busy);
    end
    wait_idle("pp_drain");
    n_cmp++;
    if (rx_q.size() != 3) begin
      n_err++;
      $display("FAIL pp_count: frames=%0d expected 3", rx_q.size());
    end
    for (int k = 0; k < 3 && k < rx_q.size(); k++) begin
      n_cmp++;
      if (rx_q[k] !== exp_bytes[k]) begin
        n_err++;
        $display("FAIL pp_byte%0d: got %h expected %h", k, rx_q[k], exp_bytes[k]);
      end
    end
  endtask

  task automatic test_reset_midframe;
    write_byte(8'h00);
    repeat (2) @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h77;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (15) @(negedge clk);
    n_cmp++;
    if ({uart_tx, level, busy} !== {1'b0, 5'd1, 1'b1}) begin
      n_err++;
      $display("FAIL rst_pre: tx/level/busy=%b/%0d/%b expected 0/1/1", uart_tx, level, busy);
    end
    rstd = 1'b0;
    #1;
    n_cmp++;
    if (uart_tx !== 1'b1) begin
      n_err++;
      $display("FAIL rst_async: uart_tx=%b expected 1", uart_tx);
    end
    repeat (2) @(negedge clk);
    rstd = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({empty, busy, level, uart_tx} !== {1'b1, 1'b0, 5'd0, 1'b1}) begin
      n_err++;
      $display("FAIL rst_post: empty/busy/level/tx=%b/%b/%0d/%b expected 1/0/0/1",
               empty, busy, level, uart_tx);
    end
    rx_q.delete();
    write_byte(8'h3C);
    check_frame(8'h3C, 1'b0, "rst_newbyte");
    @(negedge clk);
    n_cmp++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_stream: frames=%0d first=%h busy=%b expected 1/3c/0",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_overflow();
    test_ovf_priority();
    test_drain();
    test_push_pop();
    test_reset_midframe();
    n_cmp++;
    if (rx_ferr != 0) begin
      n_err++;
      $display("FAIL framing: stop-bit errors=%0d expected 0", rx_ferr);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
